// File: rtl/cluster_pkg.sv
// rtl/cluster_pkg.sv - shared constants and types for the cluster priority encoder
//
// Purpose: VPF bus geometry, address width, frame depth and the cluster_t
//          {adr, vld} record used by the encoder pipeline and frame slots.
// Ports:   none (package).
package cluster_pkg;

  localparam int MXVPF      = 768;
  localparam int MXSEGS     = 16;
  localparam int SEGSIZE    = MXVPF / MXSEGS;
  localparam int MXCLUSTERS = 4;
  localparam int ADRB       = 10;

  localparam int LOCW = $clog2(SEGSIZE);          // local index within a segment
  localparam int CNTW = $clog2(MXCLUSTERS) + 1;   // pass counter, one spare bit to saturate
  localparam int POPW = $clog2(MXCLUSTERS + 1);   // number of valid clusters in a frame

  localparam logic [ADRB-1:0] INVALID_ADR = '1;

  typedef struct packed {
    logic [ADRB-1:0] adr;
    logic            vld;
  } cluster_t;

  localparam cluster_t NO_CLUSTER = '{adr: INVALID_ADR, vld: 1'b0};

  function automatic logic [POPW-1:0] count_valid(input logic [MXCLUSTERS-1:0] v);
    logic [POPW-1:0] n;
    n = '0;
    for (int i = 0; i < MXCLUSTERS; i++) n = n + POPW'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/segment_lsb_encoder.sv
// rtl/segment_lsb_encoder.sv - lowest-set-bit encoder for one VPF segment
//
// Purpose: combinational per-segment encode feeding stage 1 of the pipeline.
// Ports:   seg   in  SEGSIZE  segment slice of the VPF bus
//          any   out 1        at least one bit set
//          idx   out LOCW     index of the lowest set bit (0 when none)
//          multi out 1        more than one bit set
module segment_lsb_encoder
  import cluster_pkg::*;
(
  input  logic [SEGSIZE-1:0] seg,
  output logic               any,
  output logic [LOCW-1:0]    idx,
  output logic               multi
);

  // Scan from the top so the lowest set bit is the last one assigned.
  always_comb begin
    idx = '0;
    for (int i = SEGSIZE - 1; i >= 0; i--) begin
      if (seg[i]) idx = LOCW'(i);
    end
  end

  assign any = |seg;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(seg & (seg - SEGSIZE'(1)));

endmodule

// File: rtl/cluster_priority_encoder.sv
// rtl/cluster_priority_encoder.sv - two-stage LSB priority encoder collecting cluster frames
//
// Purpose: encodes the lowest set bit of each truncator pass, gathers
//          MXCLUSTERS passes per latch period into a frame and strobes it out.
//          Optional macro CLUSTER_COUNT_EN adds the cluster_count output.
// Ports:   clock          in  1                fabric clock
//          reset_n        in  1                asynchronous active-low reset
//          latch_pulse    in  1                marks pass 0 (arrives on vpfs_in next cycle)
//          vpfs_in        in  MXVPF            truncator output bus
//          cluster_adr    out MXCLUSTERS*ADRB  slot k at [k*ADRB +: ADRB]
//          cluster_vld    out MXCLUSTERS       per-slot valid
//          overflow       out 1                clusters remained after the last slot
//          clusters_ready out 1                one-cycle strobe on frame update
//          cluster_count  out POPW             valid slots in frame (CLUSTER_COUNT_EN only)
module cluster_priority_encoder
  import cluster_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       latch_pulse,
  input  logic [MXVPF-1:0]           vpfs_in,
  output logic [MXCLUSTERS*ADRB-1:0] cluster_adr,
  output logic [MXCLUSTERS-1:0]      cluster_vld,
  output logic                       overflow,
  output logic                       clusters_ready
`ifdef CLUSTER_COUNT_EN
  ,
  output logic [POPW-1:0]            cluster_count
`endif
);

  // Stage 1: per-segment encode, registered.
  logic [MXSEGS-1:0] seg_any_c, seg_multi_c;
  logic [LOCW-1:0]   seg_idx_c [MXSEGS];
  logic [MXSEGS-1:0] s1_any, s1_multi;
  logic [LOCW-1:0]   s1_idx [MXSEGS];

  for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
    segment_lsb_encoder u_enc (
      .seg   (vpfs_in[g*SEGSIZE +: SEGSIZE]),
      .any   (seg_any_c[g]),
      .idx   (seg_idx_c[g]),
      .multi (seg_multi_c[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_any   <= '0;
      s1_multi <= '0;
      for (int s = 0; s < MXSEGS; s++) s1_idx[s] <= '0;
    end else begin
      s1_any   <= seg_any_c;
      s1_multi <= seg_multi_c;
      for (int s = 0; s < MXSEGS; s++) s1_idx[s] <= seg_idx_c[s];
    end
  end

  // Stage 2: lowest active segment wins; "more" if the winner holds several
  // bits or any segment above it is also active.
  cluster_t win_c, s2_res;
  logic     more_c, s2_more, above;

  always_comb begin
    win_c  = NO_CLUSTER;
    more_c = 1'b0;
    above  = 1'b0;
    for (int s = MXSEGS - 1; s >= 0; s--) begin
      if (s1_any[s]) begin
        win_c.adr = ADRB'(s * SEGSIZE) + ADRB'(s1_idx[s]);
        win_c.vld = 1'b1;
        more_c    = s1_multi[s] | above;
        above     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_res  <= NO_CLUSTER;
      s2_more <= 1'b0;
    end else begin
      s2_res  <= win_c;
      s2_more <= more_c;
    end
  end

  // Latch pulse delayed to line up with the stage-2 result of pass 0.
  logic [2:0]      lp_dly;
  logic [CNTW-1:0] pass_cnt, eff_idx;
  logic            wr_en, last_slot;

  always_comb begin
    eff_idx   = lp_dly[2] ? '0 : pass_cnt;
    wr_en     = eff_idx < CNTW'(MXCLUSTERS);
    last_slot = eff_idx == CNTW'(MXCLUSTERS - 1);
  end

  // Frame assembly: the last slot bypasses storage since it is written this cycle.
  cluster_t              slot    [MXCLUSTERS];
  cluster_t              frame_c [MXCLUSTERS];
  logic [MXCLUSTERS-1:0] frame_vld_c;

  always_comb begin
    for (int k = 0; k < MXCLUSTERS; k++) begin
      frame_c[k]     = (k == MXCLUSTERS - 1) ? s2_res : slot[k];
      frame_vld_c[k] = frame_c[k].vld;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lp_dly   <= '0;
      pass_cnt <= CNTW'(MXCLUSTERS);   // saturated: idle until a latch arrives
      for (int k = 0; k < MXCLUSTERS; k++) slot[k] <= NO_CLUSTER;
    end else begin
      lp_dly   <= {lp_dly[1:0], latch_pulse};
      pass_cnt <= wr_en ? eff_idx + CNTW'(1) : eff_idx;
      if (wr_en) slot[eff_idx[CNTW-2:0]] <= s2_res;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cluster_adr    <= {MXCLUSTERS{INVALID_ADR}};
      cluster_vld    <= '0;
      overflow       <= 1'b0;
      clusters_ready <= 1'b0;
`ifdef CLUSTER_COUNT_EN
      cluster_count  <= '0;
`endif
    end else begin
      clusters_ready <= last_slot;
      if (last_slot) begin
        for (int k = 0; k < MXCLUSTERS; k++) cluster_adr[k*ADRB +: ADRB] <= frame_c[k].adr;
        cluster_vld <= frame_vld_c;
        overflow    <= s2_more;
`ifdef CLUSTER_COUNT_EN
        cluster_count <= count_valid(frame_vld_c);
`endif
      end
    end
  end

endmodule

// File: tb/tb_cluster_priority_encoder.sv
// tb/tb_cluster_priority_encoder.sv - scoreboard bench for cluster_priority_encoder
module tb_cluster_priority_encoder;
  import cluster_pkg::*;

  logic                       clock = 1'b0;
  logic                       reset_n = 1'b0;
  logic                       latch_pulse = 1'b0;
  logic [MXVPF-1:0]           vpfs_in = '0;
  logic [MXCLUSTERS*ADRB-1:0] cluster_adr;
  logic [MXCLUSTERS-1:0]      cluster_vld;
  logic                       overflow;
  logic                       clusters_ready;
`ifdef CLUSTER_COUNT_EN
  logic [POPW-1:0]            cluster_count;
`endif

  cluster_priority_encoder dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .latch_pulse    (latch_pulse),
    .vpfs_in        (vpfs_in),
    .cluster_adr    (cluster_adr),
    .cluster_vld    (cluster_vld),
    .overflow       (overflow),
    .clusters_ready (clusters_ready)
`ifdef CLUSTER_COUNT_EN
    ,
    .cluster_count  (cluster_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [MXCLUSTERS*ADRB-1:0] adr;
    logic [MXCLUSTERS-1:0]      vld;
    logic                       ovf;
    int                         cnt;
    int                         at;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [MXCLUSTERS*ADRB-1:0] held_adr = {MXCLUSTERS{INVALID_ADR}};
  logic [MXCLUSTERS-1:0]      held_vld = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [MXCLUSTERS*ADRB-1:0] adrs(input logic [ADRB-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [MXVPF-1:0] bv(input int b0, b1, b2, b3, b4);
    logic [MXVPF-1:0] v;
    int b[5];
    b = '{b0, b1, b2, b3, b4};
    v = '0;
    for (int i = 0; i < 5; i++) if (b[i] >= 0) v[b[i]] = 1'b1;
    return v;
  endfunction

  // Called in the latch cycle L; the strobe is due in cycle L+7.
  task automatic expect_frame(input logic [MXCLUSTERS*ADRB-1:0] a, input logic [MXCLUSTERS-1:0] v,
                              input logic o, input int cnt);
    exp_t e;
    e.adr = a; e.vld = v; e.ovf = o; e.cnt = cnt; e.at = cyc + 7;
    sb.push_back(e);
  endtask

  // Latch cycle, then npass truncator passes (lowest set bit removed each pass).
  task automatic frame(input logic [MXVPF-1:0] v, input int npass);
    logic [MXVPF-1:0] p;
    p = v;
    latch_pulse = 1'b1;
    vpfs_in     = '0;
    step();
    latch_pulse = 1'b0;
    for (int k = 0; k < npass; k++) begin
      vpfs_in = p;
      p = p & (p - 1'b1);
      step();
    end
    vpfs_in = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adr"},   cluster_adr, {MXCLUSTERS{INVALID_ADR}});
    check({tag, "_vld"},   cluster_vld, '0);
    check({tag, "_ovf"},   overflow, 1'b0);
    check({tag, "_ready"}, clusters_ready, 1'b0);
`ifdef CLUSTER_COUNT_EN
    check({tag, "_count"}, cluster_count, '0);
`endif
  endtask

  // Monitor: every strobe must match the oldest expected frame.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && clusters_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got clusters_ready=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("frame_adr", cluster_adr, e.adr);
        check("frame_vld", cluster_vld, e.vld);
        check("frame_ovf", overflow, e.ovf);
        check("strobe_cycle", cyc, e.at);
`ifdef CLUSTER_COUNT_EN
        check("frame_count", cluster_count, e.cnt);
`endif
        held_adr = e.adr;
        held_vld = e.vld;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [ADRB-1:0] IV = INVALID_ADR;

  initial begin
    logic [MXVPF-1:0] p;

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();
    step();

    expect_frame(adrs(10'd5, IV, IV, IV), 4'b0001, 1'b0, 1);
    frame(bv(5, -1, -1, -1, -1), 8);

    expect_frame(adrs(10'd3, 10'd47, 10'd48, 10'd767), 4'b1111, 1'b0, 4);
    frame(bv(3, 47, 48, 767, -1), 8);

    expect_frame(adrs(10'd0, 10'd100, 10'd200, 10'd300), 4'b1111, 1'b1, 4);
    frame(bv(0, 100, 200, 300, 400), 8);

    expect_frame(adrs(10'd47, 10'd48, IV, IV), 4'b0011, 1'b0, 2);
    frame(bv(47, 48, -1, -1, -1), 8);

    // Last pass holds 47 and 48 in adjacent segments: overflow via higher segment.
    expect_frame(adrs(10'd1, 10'd2, 10'd3, 10'd47), 4'b1111, 1'b1, 4);
    frame(bv(1, 2, 3, 47, 48), 8);

    // Last pass holds 13 and 14 in one segment: overflow via multi flag.
    expect_frame(adrs(10'd10, 10'd11, 10'd12, 10'd13), 4'b1111, 1'b1, 4);
    frame(bv(10, 11, 12, 13, 14), 8);

    expect_frame({MXCLUSTERS{INVALID_ADR}}, 4'b0000, 1'b0, 0);
    frame('0, 8);

    expect_frame(adrs(10'd767, IV, IV, IV), 4'b0001, 1'b0, 1);
    frame(bv(767, -1, -1, -1, -1), 8);

    // Early latch: first frame is abandoned, outputs keep the 767 frame.
    frame(bv(0, 100, 200, 300, 400), 1);
    expect_frame(adrs(10'd3, 10'd47, 10'd48, 10'd767), 4'b1111, 1'b0, 4);
    check("early_hold_adr", cluster_adr, held_adr);
    check("early_hold_vld", cluster_vld, held_vld);
    frame(bv(3, 47, 48, 767, -1), 8);

    // Reset asserted in cycle L+4 of a frame that is never expected to complete.
    p = bv(0, 100, 200, 300, 400);
    latch_pulse = 1'b1;
    vpfs_in     = '0;
    step();
    latch_pulse = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vpfs_in = p;
      p = p & (p - 1'b1);
      step();
    end
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    vpfs_in = '0;
    step();
    step();
    reset_n = 1'b1;
    repeat (10) step();
    check("post_reset_idle_vld", cluster_vld, '0);

    expect_frame(adrs(10'd0, 10'd100, 10'd200, 10'd300), 4'b1111, 1'b1, 4);
    frame(bv(0, 100, 200, 300, 400), 8);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    check("scoreboard_drained", sb.size(), 0);
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
